alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle controller that owns one shared WIDTH-bit ripple adder (full-adder chain with carry-in) and sequences it through one or two passes per operation.
- Accepts an operation request over a req/ready handshake, runs the adder pass(es), and holds the registered result until the consumer acks.
- Sits between the lab's switch/input capture logic and the result display/overflow LED logic.

Parameters:
WIDTH, 4, operand/result width in bits; signed two's complement; must be ≥ 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req  input  1  request strobe; sampled only while ready=1.
op  input  3  opcode: 000 ADD, 001 SUB, 010 ABS, 011 ABSDIFF, 100 NEG; others illegal (see Optional Feature).
V1  input  WIDTH  operand A; captured on acceptance.
V2  input  WIDTH  operand B; captured on acceptance; ignored by ABS/NEG.
ready  output  1  high only in IDLE.
valid  output  1  result valid; held until ack.
ack  input  1  consumer accepts result; ignored when valid=0.
R  output  WIDTH  result, registered.
ovf  output  1  signed overflow of the operation, registered.
err  output  1  illegal opcode flag, registered, qualified by valid.

Behaviour:
- Reset values: ready=1 (state IDLE), valid=0, R=0, ovf=0, err=0; operand registers and pass flags are cleared.
- rst has priority over everything, including mid-operation and DONE; the next cycle is IDLE, with no result produced.
- States: IDLE, EXEC1, EXEC2, DONE.
- IDLE: if req=1, capture V1, V2 and op into registers and go to EXEC1. Otherwise stay.
- EXEC1: drive the adder and register its sum into R.
  - ADD: A + B, cin=0.
  - SUB and ABSDIFF: A + ~B, cin=1.
  - NEG: ~A + 0, cin=1.
  - ABS: if A[MSB]=1, same as NEG; else A + 0, cin=0.
  - Next state: ABSDIFF goes to EXEC2; all other ops go to DONE.
- EXEC2 (ABSDIFF only): take the intermediate D from R. If D[MSB]=1, R ← ~D + 1 via the adder; else R unchanged. Go to DONE.
- DONE: valid=1. If ack=1, return to IDLE (valid drops the next cycle). While waiting, R/ovf/err remain stable.
- Latency from the accepting edge to valid high:
  - 1 cycle for ADD, SUB, ABS, NEG.
  - 2 cycles for ABSDIFF.
  - Minimum request-to-request spacing is latency + 2 (DONE + IDLE).
- Overflow is signed: carry into MSB XOR carry out of MSB, computed per pass. ovf is the OR over all passes of the operation.
  - ABS(−2^(W−1)) and NEG(−2^(W−1)) return −2^(W−1) with ovf=1.
  - ABSDIFF where A−B overflows: R is the absolute value of the wrapped difference, ovf=1.
- Illegal opcode: EXEC1 performs no adder pass. DONE is reached with R=0, ovf=0, err=1.
- The adder is strictly combinational; only R, ovf, err, operand registers and state are flopped.
- req while ready=0 is ignored (it is not queued).
- ack arriving in the same cycle valid rises is legal: the result is presented for exactly one cycle.

Optional Feature:
- Macro: ALU_SEQ_ACC_EN.
- When defined:
  - Adds an internal WIDTH-bit accumulator, reset to 0.
  - op 101 ACC: R ← acc + A, 1 pass; acc is updated to R at DONE entry; ovf per the normal rules.
  - op 110 CLRACC: acc ← 0, R=0, 1 cycle latency, ovf=0.
  - Accumulator contents survive across other ops; only rst clears them, apart from CLRACC.
- When undefined: 101 and 110 are illegal (err=1). No accumulator flops are synthesized.

Test Plan:
- Reset, then ADD V1=3, V2=4 → valid 1 cycle after acceptance, R=0111, ovf=0, err=0; ack → ready=1 next cycle.
- ADD 7+1 → R=1000, ovf=1; SUB 2−5 → R=1101, ovf=0; SUB (−8)−1 → R=0111, ovf=1.
- ABS −8 → R=1000, ovf=1; ABS −3 → R=0011; NEG 5 → R=1011, ovf=0.
- ABSDIFF 2,6 → valid 2 cycles after acceptance, R=0100, ovf=0; ABSDIFF 7,−8 → ovf=1.
- Hold ack=0 for 5 cycles in DONE → R stable, a second req is ignored; assert rst during EXEC2 of ABSDIFF → next cycle IDLE, valid=0, R=0.
- op=111 → R=0, err=1. With ALU_SEQ_ACC_EN: ACC 3, ACC 4, ACC 2 → R=0011, 0111, 1001 with ovf=1 on the third; CLRACC then ACC 1 → R=0001.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer sharing one ripple adder across one or two passes.
// Optional accumulator ops (ACC, CLRACC) enabled by defining ALU_SEQ_ACC_EN.
module alu_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] V1,
  input  logic [WIDTH-1:0] V2,
  output logic             ready,
  output logic             valid,
  input  logic             ack,
  output logic [WIDTH-1:0] R,
  output logic             ovf,
  output logic             err
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ABS  = 3'b010;
  localparam logic [2:0] OP_ABSD = 3'b011;
  localparam logic [2:0] OP_NEG  = 3'b100;
`ifdef ALU_SEQ_ACC_EN
  localparam logic [2:0] OP_ACC  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
`endif

  typedef enum logic [1:0] {
    IDLE,
    EXEC1,
    EXEC2,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a, b;
  logic [2:0]       opr;
  logic [WIDTH-1:0] ax, ay, sum;
  logic             cin, cmsb, cout, pass_ovf;
  logic             pass, bad;
`ifdef ALU_SEQ_ACC_EN
  logic [WIDTH-1:0] acc;
  logic             clr;
`endif

  // Returns {carry out, carry into MSB, sum}
  function automatic logic [WIDTH+1:0] ripple(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             ci
  );
    logic             c;
    logic             cm;
    logic [WIDTH-1:0] s;
    c  = ci;
    cm = ci;
    s  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) cm = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, cm, s};
  endfunction

  assign {cout, cmsb, sum} = ripple(ax, ay, cin);
  assign pass_ovf = cout ^ cmsb;

  always_comb begin
    ax   = a;
    ay   = b;
    cin  = 1'b0;
    pass = 1'b1;
    bad  = 1'b0;
`ifdef ALU_SEQ_ACC_EN
    clr  = 1'b0;
`endif
    if (state == EXEC2) begin
      ax  = ~R;
      ay  = '0;
      cin = 1'b1;
    end else begin
      unique case (opr)
        OP_ADD: ;
        OP_SUB, OP_ABSD: begin
          ay  = ~b;
          cin = 1'b1;
        end
        OP_NEG: begin
          ax  = ~a;
          ay  = '0;
          cin = 1'b1;
        end
        OP_ABS: begin
          ay = '0;
          if (a[WIDTH-1]) begin
            ax  = ~a;
            cin = 1'b1;
          end
        end
`ifdef ALU_SEQ_ACC_EN
        OP_ACC: begin
          ax = acc;
          ay = a;
        end
        OP_CLR: begin
          pass = 1'b0;
          clr  = 1'b1;
        end
`endif
        default: begin
          pass = 1'b0;
          bad  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (req) state_nx = EXEC1;
      EXEC1: state_nx = (opr == OP_ABSD) ? EXEC2 : DONE;
      EXEC2: state_nx = DONE;
      DONE:  if (ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a   <= '0;
      b   <= '0;
      opr <= '0;
      R   <= '0;
      ovf <= 1'b0;
      err <= 1'b0;
`ifdef ALU_SEQ_ACC_EN
      acc <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            a   <= V1;
            b   <= V2;
            opr <= op;
          end
        end
        EXEC1: begin
          R   <= pass ? sum : '0;
          ovf <= pass & pass_ovf;
          err <= bad;
`ifdef ALU_SEQ_ACC_EN
          if (opr == OP_ACC) acc <= sum;
          if (clr)           acc <= '0;
`endif
        end
        EXEC2: begin
          // Negate only a negative intermediate difference
          if (R[WIDTH-1]) begin
            R   <= sum;
            ovf <= ovf | pass_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign valid = (state == DONE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed table-driven bench for alu_sequencer (WIDTH=4).
// Accumulator vectors are included when ALU_SEQ_ACC_EN is defined.
module tb_alu_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, req, ack;
  logic [2:0]   op;
  logic [W-1:0] V1, V2, R;
  logic         ready, valid, ovf, err;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op),
    .V1(V1), .V2(V2), .ready(ready), .valid(valid),
    .ack(ack), .R(R), .ovf(ovf), .err(err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      nm;
    logic [2:0] op;
    logic [3:0] v1;
    logic [3:0] v2;
    logic [3:0] r;
    logic       o;
    logic       e;
    int         lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [3:0] x,
                       input logic [3:0] y);
    @(negedge clk);
    chk("ready_before_req", {31'd0, ready}, 32'd1);
    op  = o;
    V1  = x;
    V2  = y;
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid && lat < 8) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic ack_it();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    chk("ready_after_ack", {31'd0, ready}, 32'd1);
    chk("valid_after_ack", {31'd0, valid}, 32'd0);
  endtask

  function automatic vec_t mk(input string nm, input logic [2:0] o,
                              input logic [3:0] x, input logic [3:0] y,
                              input logic [3:0] r, input logic ov,
                              input logic e, input int lat);
    vec_t v;
    v.nm = nm; v.op = o; v.v1 = x; v.v2 = y;
    v.r = r; v.o = ov; v.e = e; v.lat = lat;
    return v;
  endfunction

  initial begin
    int lat;
    int cnt;
    logic [3:0] rseen;
    req = 0; ack = 0; op = 0; V1 = 0; V2 = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_R", {28'd0, R}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk) rst = 0;

    tbl.push_back(mk("add_3_4",    3'b000, 4'd3, 4'd4, 4'b0111, 0, 0, 1));
    tbl.push_back(mk("add_7_1",    3'b000, 4'd7, 4'd1, 4'b1000, 1, 0, 1));
    tbl.push_back(mk("sub_2_5",    3'b001, 4'd2, 4'd5, 4'b1101, 0, 0, 1));
    tbl.push_back(mk("sub_m8_1",   3'b001, 4'h8, 4'd1, 4'b0111, 1, 0, 1));
    tbl.push_back(mk("abs_m8",     3'b010, 4'h8, 4'd5, 4'b1000, 1, 0, 1));
    tbl.push_back(mk("abs_m3",     3'b010, 4'hd, 4'd0, 4'b0011, 0, 0, 1));
    tbl.push_back(mk("neg_5",      3'b100, 4'd5, 4'd9, 4'b1011, 0, 0, 1));
    tbl.push_back(mk("neg_0",      3'b100, 4'd0, 4'd0, 4'b0000, 0, 0, 1));
    tbl.push_back(mk("absd_2_6",   3'b011, 4'd2, 4'd6, 4'b0100, 0, 0, 2));
    tbl.push_back(mk("absd_6_2",   3'b011, 4'd6, 4'd2, 4'b0100, 0, 0, 2));
    tbl.push_back(mk("absd_7_m8",  3'b011, 4'd7, 4'h8, 4'b0001, 1, 0, 2));
    tbl.push_back(mk("absd_m8_0",  3'b011, 4'h8, 4'd0, 4'b1000, 1, 0, 2));
    tbl.push_back(mk("illegal111", 3'b111, 4'd5, 4'd5, 4'b0000, 0, 1, 1));
`ifdef ALU_SEQ_ACC_EN
    tbl.push_back(mk("acc_3",      3'b101, 4'd3, 4'd0, 4'b0011, 0, 0, 1));
    tbl.push_back(mk("acc_4",      3'b101, 4'd4, 4'd0, 4'b0111, 0, 0, 1));
    tbl.push_back(mk("acc_2",      3'b101, 4'd2, 4'd0, 4'b1001, 1, 0, 1));
    tbl.push_back(mk("clracc",     3'b110, 4'd7, 4'd7, 4'b0000, 0, 0, 1));
    tbl.push_back(mk("acc_1",      3'b101, 4'd1, 4'd0, 4'b0001, 0, 0, 1));
`else
    tbl.push_back(mk("illegal101", 3'b101, 4'd3, 4'd0, 4'b0000, 0, 1, 1));
    tbl.push_back(mk("illegal110", 3'b110, 4'd3, 4'd0, 4'b0000, 0, 1, 1));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i].op, tbl[i].v1, tbl[i].v2);
      wait_valid(lat);
      chk({tbl[i].nm, "_lat"}, lat, tbl[i].lat);
      chk({tbl[i].nm, "_R"}, {28'd0, R}, {28'd0, tbl[i].r});
      chk({tbl[i].nm, "_ovf"}, {31'd0, ovf}, {31'd0, tbl[i].o});
      chk({tbl[i].nm, "_err"}, {31'd0, err}, {31'd0, tbl[i].e});
      ack_it();
    end

    // Hold in DONE with ack low; a second request must be dropped
    issue(3'b000, 4'd2, 4'd3);
    wait_valid(lat);
    chk("hold_lat", lat, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req = 1'b1; op = 3'b001; V1 = 4'd7; V2 = 4'd7;
      @(posedge clk);
      #1;
      chk("hold_R", {28'd0, R}, 32'd5);
      chk("hold_valid", {31'd0, valid}, 32'd1);
      chk("hold_ready", {31'd0, ready}, 32'd0);
    end
    @(negedge clk) req = 1'b0;
    ack_it();
    repeat (2) @(posedge clk);
    #1;
    chk("no_queue_valid", {31'd0, valid}, 32'd0);
    chk("no_queue_ready", {31'd0, ready}, 32'd1);

    // ack already high when valid rises: one-cycle result
    @(negedge clk) ack = 1'b1;
    issue(3'b000, 4'd1, 4'd1);
    cnt = 0;
    rseen = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        cnt++;
        rseen = R;
      end
    end
    chk("ack_early_cycles", cnt, 1);
    chk("ack_early_R", {28'd0, rseen}, 32'd2);
    ack = 1'b0;

    // Reset while in EXEC2 of ABSDIFF
    issue(3'b011, 4'd2, 4'd6);
    @(posedge clk);
    #1;
    chk("exec2_valid", {31'd0, valid}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_R", {28'd0, R}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_valid", {31'd0, valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
